data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the core's data-memory interface: accepts address/data/write from the
//  pipeline MEM stage and returns read data in the same cycle (the core has no memory stall).
//  Holds a DEPTH-word, word-addressed data RAM plus four memory-mapped registers:
//  GPIO out, free-running cycle counter, sticky error status, and synchronised GPIO in.
// PARAMETERS
//  DEPTH      64             RAM words; power of two, 2..1024
//  MMIO_BASE  32'hFFFF_FFF0  word address of first MMIO register (4 consecutive words)
//  GPIO_W     8              GPIO in/out width, 1..32
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  addr_in    in   32      word address (core ALU result in MEM stage)
//  wdata_in   in   32      write data
//  write_in   in   1       write strobe; commits at the rising edge while high
//  rdata_out  out  32      read data, combinational from addr_in
//  gpio_in    in   GPIO_W  asynchronous external inputs
//  gpio_out   out  GPIO_W  GPIO_OUT register value
//  err_out    out  1       OR of STATUS bits
// BEHAVIOUR
//  Address map (full 32-bit compare, no aliasing):
//   0..DEPTH-1   RAM word, read/write
//   MMIO_BASE+0  GPIO_OUT   rw; bits [GPIO_W-1:0], upper bits read 0
//   MMIO_BASE+1  CYCLE      ro; 32-bit counter, +1 every clk, wraps FFFF_FFFF->0
//   MMIO_BASE+2  STATUS     bit0 OOB, bit1 RO_ERR; sticky; write 1 to clear that bit
//   MMIO_BASE+3  GPIO_IN    ro; gpio_in after 2-flop synchroniser, upper bits 0
//   anything else: unmapped
//  Reads: purely combinational, zero latency, no side effects; unmapped -> 32'h0.
//  Writes: take effect at the rising edge where write_in=1; same-cycle read returns old
//   value; read in the next cycle returns new value.
//  Error capture (only when write_in=1):
//   unmapped address -> write dropped, STATUS.OOB <= 1
//   write to CYCLE or GPIO_IN -> write dropped, STATUS.RO_ERR <= 1
//   reads never set error bits
//  STATUS W1C: bits written 1 clear, bits written 0 unchanged. W1C write is never itself
//   an error, so clear and set cannot occur in the same cycle (exclusive address).
//  CYCLE is not writable; it counts through and after any write attempt.
//  err_out = |STATUS, registered-state derived (no combinational path from inputs).
//  gpio_in sync: stage1 <= gpio_in, stage2 <= stage1; GPIO_IN reads stage2
//   (2-cycle latency from pin change to readable value).
//  Reset (rst_n=0, asynchronous): all RAM words, GPIO_OUT, CYCLE, STATUS and sync
//   flops -> 0; therefore gpio_out=0, err_out=0, rdata_out=0 for every mapped address.
//   A write pending in the edge where rst_n is low is lost. CYCLE reads 0 in the first
//   cycle after release and 1 in the next.
//  RAM index = addr_in[$clog2(DEPTH)-1:0], used only when addr_in < DEPTH.
// TESTING
//  1. Reset, write 32'hDEAD_BEEF to addr 5, read addr 5 in the same cycle -> 0; next
//     cycle -> DEAD_BEEF; addr 6 -> 0.
//  2. Write to addr DEPTH (64) with data 1 -> RAM unchanged, STATUS=1, err_out=1;
//     write 32'h1 to MMIO_BASE+2 -> STATUS=0, err_out=0 next cycle.
//  3. Write MMIO_BASE+1 -> CYCLE keeps counting, STATUS=2; write MMIO_BASE+3 -> STATUS=2;
//     write MMIO_BASE+2 with 32'h1 -> STATUS stays 2.
//  4. Write 32'h1A5 to MMIO_BASE+0 (GPIO_W=8) -> gpio_out=8'hA5, readback 32'h0000_00A5.
//  5. Drive gpio_in=8'h3C -> GPIO_IN reads old value for two edges, 32'h3C after second.
//  6. Force CYCLE to FFFF_FFFE via run/preload -> reads FFFF_FFFF then 0; then assert
//     rst_n low mid-write -> all outputs 0 immediately, written word not stored.

Source files
------------

// File: rtl/data_mem_responder.sv
// Responder side of the core data-memory port: word-addressed RAM plus four MMIO registers
// (GPIO out, cycle counter, sticky W1C status, synchronised GPIO in), zero-latency reads.
module data_mem_responder #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FFF0,
  parameter int unsigned GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       wdata_in,
  input  logic              write_in,
  output logic [31:0]       rdata_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              err_out
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [1:0]  OFF_GPIO_OUT = 2'd0;
  localparam logic [1:0]  OFF_CYCLE    = 2'd1;
  localparam logic [1:0]  OFF_STATUS   = 2'd2;
  localparam logic [1:0]  OFF_GPIO_IN  = 2'd3;

  logic [31:0]       ram_q [DEPTH];
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [1:0]        status_q, status_d;
  logic [GPIO_W-1:0] sync1_q, sync2_q;

  logic [31:0]   mmio_off;
  logic          ram_hit, mmio_hit, ram_we, gpio_we;
  logic [AW-1:0] ram_idx;
  logic [1:0]    status_set, status_clr;

  // Address decode: full 32-bit compare, RAM window first, then the four MMIO words.
  always_comb begin
    mmio_off = addr_in - MMIO_BASE;
    ram_hit  = addr_in < DEPTH_W;
    mmio_hit = !ram_hit && (mmio_off[31:2] == 30'd0);
    ram_idx  = addr_in[AW-1:0];
  end

  // Write side: commit enables, error capture and W1C clear.
  always_comb begin
    ram_we     = 1'b0;
    gpio_we    = 1'b0;
    status_set = 2'b00;
    status_clr = 2'b00;
    if (write_in) begin
      if (ram_hit) begin
        ram_we = 1'b1;
      end else if (mmio_hit) begin
        case (mmio_off[1:0])
          OFF_GPIO_OUT: gpio_we    = 1'b1;
          OFF_STATUS:   status_clr = wdata_in[1:0];
          default:      status_set = 2'b10;
        endcase
      end else begin
        status_set = 2'b01;
      end
    end
    gpio_out_d = gpio_we ? wdata_in[GPIO_W-1:0] : gpio_out_q;
    status_d   = (status_q & ~status_clr) | status_set;
    cycle_d    = cycle_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) ram_q[i] <= '0;
    end else if (ram_we) begin
      ram_q[ram_idx] <= wdata_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_out_q <= '0;
      cycle_q    <= '0;
      status_q   <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      cycle_q    <= cycle_d;
      status_q   <= status_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
    end
  end

  // Read mux: combinational from addr_in, unmapped reads return zero.
  always_comb begin
    rdata_out = '0;
    if (ram_hit) begin
      rdata_out = ram_q[ram_idx];
    end else if (mmio_hit) begin
      case (mmio_off[1:0])
        OFF_GPIO_OUT: rdata_out = 32'(gpio_out_q);
        OFF_CYCLE:    rdata_out = cycle_q;
        OFF_STATUS:   rdata_out = 32'(status_q);
        OFF_GPIO_IN:  rdata_out = 32'(sync2_q);
        default:      rdata_out = '0;
      endcase
    end
  end

  assign gpio_out = gpio_out_q;
  assign err_out  = |status_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder against a behavioural memory-map model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr_in, wdata_in, rdata_out;
  logic        write_in;
  logic [7:0]  gpio_in, gpio_out;
  logic        err_out;

  int nvec = 0;
  int nerr = 0;

  // Reference state: what a program would observe through the memory map.
  logic [31:0] m_ram [DEPTH];
  logic [7:0]  m_gpio;
  logic [31:0] m_cycle;
  logic [1:0]  m_status;
  logic [7:0]  m_pin_hist [2];

  data_mem_responder #(.DEPTH(DEPTH), .MMIO_BASE(BASE), .GPIO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .wdata_in(wdata_in),
    .write_in(write_in), .rdata_out(rdata_out), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < DEPTH; i++) m_ram[i] = '0;
    m_gpio = '0; m_cycle = '0; m_status = '0;
    m_pin_hist[0] = '0; m_pin_hist[1] = '0;
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (a < 32'(DEPTH)) return m_ram[a];
    case (off)
      32'd0:   return {24'd0, m_gpio};
      32'd1:   return m_cycle;
      32'd2:   return {30'd0, m_status};
      32'd3:   return {24'd0, m_pin_hist[1]};
      default: return 32'd0;
    endcase
  endfunction

  // Drive one bus beat at the falling edge and compare all outputs with the model.
  task automatic apply(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    write_in = w; addr_in = a; wdata_in = d;
    #1;
    chk("rdata", rdata_out, mread(a));
    chk("gpio_out", 32'(gpio_out), 32'(m_gpio));
    chk("err_out", 32'(err_out), 32'(|m_status));
  endtask

  // Rising edge: apply the pending beat to the model.
  task automatic tick();
    logic [31:0] off;
    @(posedge clk);
    off = addr_in - BASE;
    if (write_in) begin
      if (addr_in < 32'(DEPTH)) m_ram[addr_in] = wdata_in;
      else if (off == 32'd0) m_gpio = wdata_in[7:0];
      else if (off == 32'd2) m_status = m_status & ~wdata_in[1:0];
      else if (off == 32'd1 || off == 32'd3) m_status = m_status | 2'b10;
      else m_status = m_status | 2'b01;
    end
    m_cycle++;
    m_pin_hist[1] = m_pin_hist[0];
    m_pin_hist[0] = gpio_in;
  endtask

  initial begin
    logic [31:0] a, c0;
    rst_n = 1'b0; write_in = 1'b0; addr_in = '0; wdata_in = '0; gpio_in = '0;
    mreset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset state and first-cycle counter value.
    apply(0, BASE + 32'd1, 0); chk("rst_cycle0", rdata_out, 32'd0);
    chk("rst_gpio", 32'(gpio_out), 32'd0); chk("rst_err", 32'(err_out), 32'd0); tick();
    apply(0, BASE + 32'd1, 0); chk("rst_cycle1", rdata_out, 32'd1); tick();

    // RAM write: old value same cycle, new value next cycle, neighbour untouched.
    apply(1, 32'd5, 32'hDEAD_BEEF); chk("t1_same", rdata_out, 32'd0); tick();
    apply(0, 32'd5, 0); chk("t1_next", rdata_out, 32'hDEAD_BEEF); tick();
    apply(0, 32'd6, 0); chk("t1_nbr", rdata_out, 32'd0); tick();

    // Out-of-range write sets OOB only; W1C clears it.
    apply(1, 32'd64, 32'd1); tick();
    apply(0, 32'd0, 0); chk("t2_noalias", rdata_out, 32'd0); tick();
    apply(0, BASE + 32'd2, 0); chk("t2_status", rdata_out, 32'd1);
    chk("t2_err", 32'(err_out), 32'd1); tick();
    apply(1, BASE + 32'd2, 32'd1); tick();
    apply(0, BASE + 32'd2, 0); chk("t2_clr", rdata_out, 32'd0);
    chk("t2_err0", 32'(err_out), 32'd0); tick();

    // Read-only writes: counter unaffected, RO_ERR sticky, clearing OOB leaves it.
    apply(0, BASE + 32'd1, 0); c0 = m_cycle; tick();
    apply(1, BASE + 32'd1, 32'h0); chk("t3_cyc_a", rdata_out, c0 + 32'd1); tick();
    apply(0, BASE + 32'd1, 0); chk("t3_cyc_b", rdata_out, c0 + 32'd2); tick();
    apply(0, BASE + 32'd2, 0); chk("t3_ro", rdata_out, 32'd2); tick();
    apply(1, BASE + 32'd3, 32'hFF); tick();
    apply(1, BASE + 32'd2, 32'd1); chk("t3_ro2", rdata_out, 32'd2); tick();
    apply(0, BASE + 32'd2, 0); chk("t3_keep", rdata_out, 32'd2); tick();
    apply(1, BASE + 32'd2, 32'd2); tick();

    // GPIO out truncation and readback.
    apply(1, BASE, 32'h1A5); tick();
    apply(0, BASE, 0); chk("t4_read", rdata_out, 32'h0000_00A5);
    chk("t4_pin", 32'(gpio_out), 32'hA5); tick();

    // GPIO in: two-edge synchroniser latency.
    apply(0, BASE + 32'd3, 0); gpio_in = 8'h3C; chk("t5_e0", rdata_out, 32'd0); tick();
    apply(0, BASE + 32'd3, 0); chk("t5_e1", rdata_out, 32'd0); tick();
    apply(0, BASE + 32'd3, 0); chk("t5_e2", rdata_out, 32'h3C); tick();

    // Randomized traffic over RAM, MMIO and unmapped space.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: a = 32'($urandom_range(0, DEPTH - 1));
        5, 6, 7:       a = BASE + 32'($urandom_range(0, 3));
        8:             a = ($urandom_range(0, 1) == 0) ? 32'd64 + 32'($urandom_range(0, 15))
                                                       : BASE + 32'd4 + 32'($urandom_range(0, 11));
        default:       a = $urandom;
      endcase
      apply(1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) gpio_in = 8'($urandom);
      tick();
    end

    // Counter wrap from a preloaded value.
    @(posedge clk); #2;
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1 release dut.cycle_q;
    m_cycle = 32'hFFFF_FFFE;
    apply(0, BASE + 32'd1, 0); chk("t6_fffe", rdata_out, 32'hFFFF_FFFE); tick();
    apply(0, BASE + 32'd1, 0); chk("t6_ffff", rdata_out, 32'hFFFF_FFFF); tick();
    apply(0, BASE + 32'd1, 0); chk("t6_wrap", rdata_out, 32'd0); tick();

    // Asynchronous reset in the middle of a write.
    apply(1, BASE, 32'h5A); tick();
    apply(1, 32'd70, 32'd1); tick();
    apply(1, 32'd7, 32'h1234_5678); tick();
    apply(1, 32'd7, 32'hCAFE_0001);
    rst_n = 1'b0; #1;
    chk("t6_rst_ram", rdata_out, 32'd0);
    chk("t6_rst_gpio", 32'(gpio_out), 32'd0);
    chk("t6_rst_err", 32'(err_out), 32'd0);
    addr_in = BASE + 32'd1; #1;
    chk("t6_rst_cyc", rdata_out, 32'd0);
    addr_in = 32'd7;
    @(posedge clk); #2;
    write_in = 1'b0;
    rst_n = 1'b1;
    mreset();
    apply(0, 32'd7, 0); chk("t6_lost", rdata_out, 32'd0); tick();
    apply(0, BASE + 32'd1, 0); chk("t6_cyc_post", rdata_out, 32'd1); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
